// File: rtl/conv1d_pkg.sv
// Shared types, defaults and helpers for the multi-channel 1-D convolution engine.
// The state enum, default sizing and the 32-bit saturation function live here.
package conv1d_pkg;

   localparam int MaxKernelDef   = 16;
   localparam int MaxChannelsDef = 4;
   // A full-scale 32x32 product summed over MaxKernel taps must never wrap.
   localparam int AccWidthDef    = 64 + $clog2(MaxKernelDef);
   localparam int SatInWidth     = 96;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      LOAD_K,
      MAC,
      WRITE,
      NEXT_CH,
      FIN
   } state_e;

   function automatic logic [31:0] sat32(input logic signed [SatInWidth-1:0] v);
      if (&v[SatInWidth-1:31] || ~|v[SatInWidth-1:31]) return v[31:0];
      return v[SatInWidth-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
   endfunction

endpackage

// File: rtl/conv1d_mac.sv
// Registered signed 32x32 multiply-accumulate with synchronous clear,
// accumulate enable and a 32-bit saturated view of the running sum.
module conv1d_mac
   import conv1d_pkg::*;
#(
   parameter int AccWidth = AccWidthDef
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               clr_i,
   input  logic               en_i,
   input  logic signed [31:0] a_i,
   input  logic signed [31:0] b_i,
   output logic [31:0]        sat_o
);

   logic signed [AccWidth-1:0] acc_q;
   logic signed [63:0]         prod;

   assign prod = 64'(a_i) * 64'(b_i);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values and the simulation matches the flops.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)    acc_q <= '0;
      else if (clr_i) acc_q <= '0;
      else if (en_i)  acc_q <= acc_q + AccWidth'(prod);
   end

   assign sat_o = sat32(SatInWidth'(acc_q));

endmodule

// File: rtl/conv1d_mc_engine.sv
// Multi-channel 1-D convolution engine: loads one kernel from the shared SRAM,
// convolves up to MaxChannels input channels (VALID or SAME) and writes results back.
module conv1d_mc_engine
   import conv1d_pkg::*;
#(
   parameter int AddrWidth   = 7,
   parameter int MaxKernel   = MaxKernelDef,
   parameter int MaxChannels = MaxChannelsDef,
   parameter int AccWidth    = AccWidthDef
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  logic                 mode_same_i,
   input  logic [4:0]           k_len_i,
   input  logic [AddrWidth-1:0] in_len_i,
   input  logic [2:0]           n_ch_i,
   input  logic [AddrWidth-1:0] k_base_i,
   input  logic [AddrWidth-1:0] in_base_i,
   input  logic [AddrWidth-1:0] out_base_i,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [AddrWidth-1:0] mem_addr_o,
   output logic [31:0]          mem_wdata_o,
   input  logic [31:0]          mem_rdata_i,
   output logic                 ext_gnt_o,
   output logic                 running_o,
   output logic                 done_o,
   output logic                 error_o
);

   localparam int AW   = AddrWidth;
   localparam int TapW = $clog2(MaxKernel);
   localparam int IW   = AW + 3;

   state_e state_q, state_d;

   logic          mode_q;
   logic [4:0]    k_len_q;
   logic [AW-1:0] in_len_q, k_base_q, in_base_q, out_base_q;
   logic [2:0]    n_ch_q, ch_q;
   logic [4:0]    tap_q;
   logic [AW-1:0] out_q, in_ch_base_q, out_ch_base_q;
   logic          error_q;
   logic          acc_en_q, use_mem_q;
   logic [TapW-1:0] tap_d_q;
   logic [31:0]   kern_q [MaxKernel];

   logic          illegal, tap_active, last_tap, in_range;
   logic [AW-1:0] out_len;
   logic [IW-1:0] centre, idx;
   logic [31:0]   mac_a, mac_out;

   assign out_len    = mode_q ? in_len_q : in_len_q - AW'(k_len_q) + AW'(1);
   assign tap_active = tap_q < k_len_q;
   assign last_tap   = tap_q == k_len_q;
   // Signed tap position relative to the channel start; negative or >= in_len is padding.
   assign centre     = mode_q ? IW'(k_len_q[4:1]) : '0;
   assign idx        = IW'(out_q) + IW'(tap_q) - centre;
   assign in_range   = !idx[IW-1] && (idx < IW'(in_len_q));
   assign illegal    = (k_len_q == '0) || (k_len_q > 5'(MaxKernel)) ||
                       (n_ch_q == '0) || (n_ch_q > 3'(MaxChannels)) ||
                       (in_len_q == '0) || (!mode_q && in_len_q < AW'(k_len_q));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = CHECK;
         CHECK:   state_d = illegal ? FIN : LOAD_K;
         LOAD_K:  if (last_tap) state_d = MAC;
         MAC:     if (last_tap) state_d = WRITE;
         WRITE:   state_d = (out_q == out_len - AW'(1)) ? NEXT_CH : MAC;
         NEXT_CH: state_d = (ch_q == n_ch_q - 3'd1) ? FIN : MAC;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mode_q        <= 1'b0;
         k_len_q       <= '0;
         in_len_q      <= '0;
         n_ch_q        <= '0;
         k_base_q      <= '0;
         in_base_q     <= '0;
         out_base_q    <= '0;
         tap_q         <= '0;
         out_q         <= '0;
         ch_q          <= '0;
         in_ch_base_q  <= '0;
         out_ch_base_q <= '0;
         error_q       <= 1'b0;
         acc_en_q      <= 1'b0;
         use_mem_q     <= 1'b0;
         tap_d_q       <= '0;
      end else begin
         acc_en_q  <= (state_q == MAC) && tap_active;
         use_mem_q <= (state_q == MAC) && tap_active && in_range;
         tap_d_q   <= tap_q[TapW-1:0];
         case (state_q)
            IDLE: if (start_i) begin
               mode_q     <= mode_same_i;
               k_len_q    <= k_len_i;
               in_len_q   <= in_len_i;
               n_ch_q     <= n_ch_i;
               k_base_q   <= k_base_i;
               in_base_q  <= in_base_i;
               out_base_q <= out_base_i;
               error_q    <= 1'b0;
            end
            CHECK: begin
               error_q       <= illegal;
               tap_q         <= '0;
               out_q         <= '0;
               ch_q          <= '0;
               in_ch_base_q  <= in_base_q;
               out_ch_base_q <= out_base_q;
            end
            LOAD_K, MAC: tap_q <= last_tap ? '0 : tap_q + 5'd1;
            WRITE: begin
               tap_q <= '0;
               out_q <= (out_q == out_len - AW'(1)) ? '0 : out_q + AW'(1);
            end
            NEXT_CH: begin
               ch_q          <= ch_q + 3'd1;
               in_ch_base_q  <= in_ch_base_q + in_len_q;
               out_ch_base_q <= out_ch_base_q + out_len;
            end
            default: ;
         endcase
      end
   end

   // NOTE: the kernel file is a small register array, so it is reset like any
   // other flop; a real SRAM macro would not be.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < MaxKernel; i++) kern_q[i] <= '0;
      end else if (state_q == LOAD_K && tap_q != '0) begin
         kern_q[TapW'(tap_q - 5'd1)] <= mem_rdata_i;
      end
   end

   assign mac_a = use_mem_q ? mem_rdata_i : '0;

   conv1d_mac #(.AccWidth(AccWidth)) u_mac (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  ((state_q == WRITE) || (state_q == CHECK)),
      .en_i   (acc_en_q),
      .a_i    (mac_a),
      .b_i    (kern_q[tap_d_q]),
      .sat_o  (mac_out)
   );

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      ext_gnt_o   = 1'b0;
      running_o   = 1'b0;
      done_o      = 1'b0;
      case (state_q)
         IDLE: ext_gnt_o = 1'b1;
         FIN: begin
            ext_gnt_o = 1'b1;
            done_o    = 1'b1;
         end
         LOAD_K: begin
            running_o  = 1'b1;
            mem_req_o  = tap_active;
            mem_addr_o = tap_active ? k_base_q + AW'(tap_q) : '0;
         end
         MAC: begin
            running_o  = 1'b1;
            mem_req_o  = tap_active && in_range;
            mem_addr_o = mem_req_o ? in_ch_base_q + idx[AW-1:0] : '0;
         end
         WRITE: begin
            running_o   = 1'b1;
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = out_ch_base_q + out_q;
            mem_wdata_o = mac_out;
         end
         default: running_o = 1'b1;
      endcase
   end

   assign error_o = error_q;

endmodule

// File: tb/tb_conv1d_mc_engine.sv
// Scoreboard bench for conv1d_mc_engine: a bus-side SRAM model, a reference
// convolution computed with wide plain arithmetic, and a write monitor.
module tb_conv1d_mc_engine;

   localparam int AW = 7;
   localparam int MK = 16;
   localparam int MC = 4;

   logic          clk = 1'b0;
   logic          rst_ni, start_i, mode_same_i;
   logic [4:0]    k_len_i;
   logic [AW-1:0] in_len_i, k_base_i, in_base_i, out_base_i;
   logic [2:0]    n_ch_i;
   logic          mem_req_o, mem_we_o, ext_gnt_o, running_o, done_o, error_o;
   logic [AW-1:0] mem_addr_o;
   logic [31:0]   mem_wdata_o, mem_rdata_i;

   logic          bus_we;
   logic [AW-1:0] bus_addr;
   logic [31:0]   bus_wdata;

   always #5 clk = ~clk;

   conv1d_mc_engine dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .start_i     (start_i),
      .mode_same_i (mode_same_i),
      .k_len_i     (k_len_i),
      .in_len_i    (in_len_i),
      .n_ch_i      (n_ch_i),
      .k_base_i    (k_base_i),
      .in_base_i   (in_base_i),
      .out_base_i  (out_base_i),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i),
      .ext_gnt_o   (ext_gnt_o),
      .running_o   (running_o),
      .done_o      (done_o),
      .error_o     (error_o)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   logic [31:0]   mem [128];
   logic [31:0]   kern [MK];
   logic [31:0]   xin [MC][128];
   wr_t           exp_q[$];
   wr_t           mon_e;
   int            errors = 0, checks = 0;
   int            done_cnt = 0, wr_cnt = 0, stray_rd = 0, gnt_bad = 0;
   logic [AW-1:0] cfg_k_base, cfg_in_base;
   int            cfg_k_len = 0, cfg_in_words = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic bit in_region(input logic [AW-1:0] a);
      return (int'(AW'(a - cfg_k_base)) < cfg_k_len) ||
             (int'(AW'(a - cfg_in_base)) < cfg_in_words);
   endfunction

   // SRAM: the bridge side owns it while granted, the engine otherwise.
   always @(posedge clk) begin
      if (ext_gnt_o) begin
         if (bus_we) mem[bus_addr] <= bus_wdata;
         mem_rdata_i <= $urandom;
      end else if (mem_req_o && !mem_we_o) begin
         mem_rdata_i <= mem[mem_addr_o];
      end else begin
         if (mem_req_o) mem[mem_addr_o] <= mem_wdata_o;
         mem_rdata_i <= $urandom;
      end
   end

   always @(negedge clk) begin
      if (rst_ni) begin
         if (done_o) done_cnt++;
         if (running_o && ext_gnt_o) gnt_bad++;
         if (mem_req_o && !ext_gnt_o) begin
            if (mem_we_o) begin
               wr_cnt++;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_write: addr %0h data %0h, expected no write",
                           mem_addr_o, mem_wdata_o);
               end else begin
                  mon_e = exp_q.pop_front();
                  check("wr_addr", 32'(mem_addr_o), 32'(mon_e.addr));
                  check("wr_data", mem_wdata_o, mon_e.data);
               end
            end else if (!in_region(mem_addr_o)) begin
               stray_rd++;
            end
         end
      end
   end

   task automatic bus_write(input int a, input logic [31:0] d);
      @(negedge clk);
      bus_we    = 1'b1;
      bus_addr  = AW'(a);
      bus_wdata = d;
      @(negedge clk);
      bus_we    = 1'b0;
   endtask

   // Reference: direct convolution sums in 128-bit arithmetic, then clamp to int32.
   task automatic build_expected(input bit same, input int k, input int n, input int nch,
                                 input int ob);
      int olen = same ? n : n - k + 1;
      for (int c = 0; c < nch; c++) begin
         for (int o = 0; o < olen; o++) begin
            logic signed [127:0] acc = '0;
            logic [31:0] d;
            for (int j = 0; j < k; j++) begin
               int idx = o + j - (same ? k / 2 : 0);
               if (idx >= 0 && idx < n)
                  acc += 128'($signed(xin[c][idx])) * 128'($signed(kern[j]));
            end
            if (acc > 128'sd2147483647)       d = 32'h7FFF_FFFF;
            else if (acc < -128'sd2147483648) d = 32'h8000_0000;
            else                              d = acc[31:0];
            exp_q.push_back('{addr: AW'(ob + c * olen + o), data: d});
         end
      end
   endtask

   task automatic preload_and_kick(input bit same, input int k, input int n, input int nch,
                                   input int kb, input int ib, input int ob, input bit legal);
      for (int j = 0; j < k && j < MK; j++) bus_write(kb + j, kern[j]);
      for (int c = 0; c < nch && c < MC; c++)
         for (int i = 0; i < n; i++) bus_write(ib + c * n + i, xin[c][i]);
      cfg_k_base   = AW'(kb);
      cfg_in_base  = AW'(ib);
      cfg_k_len    = legal ? k : 0;
      cfg_in_words = legal ? n * nch : 0;
      wr_cnt = 0; done_cnt = 0; stray_rd = 0; gnt_bad = 0;
      if (legal) build_expected(same, k, n, nch, ob);
      check("idle_gnt", 32'(ext_gnt_o), 32'd1);
      @(negedge clk);
      mode_same_i = same;
      k_len_i     = 5'(k);
      in_len_i    = AW'(n);
      n_ch_i      = 3'(nch);
      k_base_i    = AW'(kb);
      in_base_i   = AW'(ib);
      out_base_i  = AW'(ob);
      start_i     = 1'b1;
      @(negedge clk);
      start_i     = 1'b0;
      mode_same_i = ~same;
      k_len_i     = 5'd9;
      in_len_i    = AW'(1);
      n_ch_i      = 3'd3;
      out_base_i  = AW'(ob + 5);
      check("gnt_after_start", 32'(ext_gnt_o), 32'd0);
      check("running_after_start", 32'(running_o), 32'd1);
      check("err_clr_on_start", 32'(error_o), 32'd0);
   endtask

   task automatic run(input bit same, input int k, input int n, input int nch,
                      input int kb, input int ib, input int ob, input bit poke);
      bit legal = !(k == 0 || k > MK || nch == 0 || nch > MC || (!same && n < k));
      int olen  = same ? n : n - k + 1;
      bit got   = 1'b0;
      preload_and_kick(same, k, n, nch, kb, ib, ob, legal);
      for (int cyc = 0; cyc < 20000; cyc++) begin
         @(negedge clk);
         start_i = poke && (cyc == 5 || cyc == 6);
         if (done_o) begin
            got = 1'b1;
            break;
         end
      end
      check("done_seen", 32'(got), 32'd1);
      check("fin_running", 32'(running_o), 32'd0);
      check("fin_gnt", 32'(ext_gnt_o), 32'd1);
      check("fin_error", 32'(error_o), 32'(!legal));
      start_i = poke;
      @(negedge clk);
      start_i = 1'b0;
      repeat (10) @(negedge clk);
      check("done_once", 32'(done_cnt), 32'd1);
      check("error_sticky", 32'(error_o), 32'(!legal));
      check("write_count", 32'(wr_cnt), legal ? 32'(nch * olen) : 32'd0);
      check("pending_writes", 32'(exp_q.size()), 32'd0);
      check("stray_reads", 32'(stray_rd), 32'd0);
      check("gnt_during_run", 32'(gnt_bad), 32'd0);
      check("idle_after", 32'(running_o), 32'd0);
      exp_q.delete();
   endtask

   task automatic rnd_fill(input int k, input int n, input int nch);
      for (int j = 0; j < k; j++)
         kern[j] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 200)) - 32'd100;
      for (int c = 0; c < nch; c++)
         for (int i = 0; i < n; i++)
            xin[c][i] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 200)) - 32'd100;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      rst_ni = 1'b0; start_i = 1'b0; mode_same_i = 1'b0; k_len_i = '0; in_len_i = '0;
      n_ch_i = '0; k_base_i = '0; in_base_i = '0; out_base_i = '0;
      bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
      #1;
      check("rst_gnt", 32'(ext_gnt_o), 32'd1);
      check("rst_running", 32'(running_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_error", 32'(error_o), 32'd0);
      check("rst_req", 32'(mem_req_o), 32'd0);
      check("rst_we", 32'(mem_we_o), 32'd0);
      repeat (3) @(negedge clk);
      rst_ni = 1'b1;

      kern[0] = 1; kern[1] = 2; kern[2] = 1;
      for (int i = 0; i < 5; i++) xin[0][i] = 32'(i + 1);
      run(1'b0, 3, 5, 1, 'h00, 'h10, 'h20, 1'b0);

      kern[0] = 1; kern[1] = 1; kern[2] = 1;
      run(1'b1, 3, 4, 1, 'h00, 'h10, 'h20, 1'b0);

      kern[0] = 1; kern[1] = 32'hFFFF_FFFF;
      xin[0][0] = 5; xin[0][1] = 3; xin[0][2] = 1;
      xin[1][0] = 32'hFFFF_FFFE; xin[1][1] = 2; xin[1][2] = 6;
      run(1'b0, 2, 3, 2, 'h00, 'h10, 'h20, 1'b0);

      kern[0] = 32'h7FFF_FFFF; kern[1] = 32'h7FFF_FFFF;
      xin[0][0] = 32'h7FFF_FFFF; xin[0][1] = 32'h7FFF_FFFF;
      run(1'b0, 2, 2, 1, 'h00, 'h10, 'h20, 1'b0);
      kern[0] = 32'h8000_0000; kern[1] = 32'h8000_0000;
      run(1'b0, 2, 2, 1, 'h00, 'h10, 'h20, 1'b0);

      run(1'b0, 0, 4, 1, 'h00, 'h10, 'h20, 1'b0);
      run(1'b0, 17, 20, 1, 'h00, 'h10, 'h40, 1'b0);
      run(1'b0, 3, 2, 1, 'h00, 'h10, 'h20, 1'b0);
      run(1'b1, 2, 3, 5, 'h00, 'h10, 'h20, 1'b0);

      kern[0] = 1; kern[1] = 2; kern[2] = 1;
      for (int i = 0; i < 5; i++) xin[0][i] = 32'(i + 1);
      run(1'b0, 3, 5, 1, 'h00, 'h10, 'h20, 1'b1);

      preload_and_kick(1'b0, 3, 5, 1, 'h00, 'h10, 'h20, 1'b1);
      repeat (15) @(negedge clk);
      #2 rst_ni = 1'b0;
      #1;
      check("abort_gnt", 32'(ext_gnt_o), 32'd1);
      check("abort_running", 32'(running_o), 32'd0);
      check("abort_done", 32'(done_o), 32'd0);
      check("abort_req", 32'(mem_req_o), 32'd0);
      exp_q.delete();
      done_cnt = 0;
      repeat (3) @(negedge clk);
      rst_ni = 1'b1;
      repeat (10) @(negedge clk);
      check("abort_no_done", 32'(done_cnt), 32'd0);
      run(1'b0, 3, 5, 1, 'h00, 'h10, 'h20, 1'b0);

      kern[0] = 3; kern[1] = 32'hFFFF_FFF9;
      for (int i = 0; i < 4; i++) xin[0][i] = 32'(10 * i + 7);
      run(1'b0, 2, 4, 1, 'h00, 'h10, 'h7F, 1'b0);

      for (int t = 0; t < 6; t++) begin
         bit same = 1'($urandom_range(0, 1));
         int k    = $urandom_range(1, same ? MK : 12);
         int n    = same ? $urandom_range(1, 12) : $urandom_range(k, 12);
         int nch  = $urandom_range(1, MC);
         rnd_fill(k, n, nch);
         run(same, k, n, nch, 'h00, 'h10, 'h40, 1'b0);
      end
      rnd_fill(MK, 12, MC);
      run(1'b1, MK, 12, MC, 'h00, 'h10, 'h40, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
